// File: rtl/mu_sched.sv
// Issue/writeback controller for the fixed-latency pipelined multiplier: credit-limited issue,
// tag pipe tracking and in-order result FIFO. Optional flush port via MU_SCHED_FLUSH_EN.
module mu_sched #(
   parameter int LAT   = 8,
   parameter int TAGW  = 5,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [31:0]     req_a,
   input  logic [31:0]     req_b,
   input  logic [1:0]      req_op,
   input  logic [TAGW-1:0] req_rd,
   output logic            mu_start,
   output logic [31:0]     mu_a,
   output logic [31:0]     mu_b,
   output logic [1:0]      mu_ctl,
   input  logic [31:0]     mu_res,
   input  logic            mu_done,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [31:0]     wb_data,
   output logic [TAGW-1:0] wb_rd,
   output logic            busy,
   output logic            err
`ifdef MU_SCHED_FLUSH_EN
   ,
   input  logic            flush
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(LAT + DEPTH + 2);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // ready never looks at valid, and the producer holds its payload until the transfer.

   logic [TAGW-1:0] issue_rd;
   logic [LAT-1:0]  tag_v;
   logic [TAGW-1:0] tag_rd [LAT];
   logic [31:0]     fifo_data [DEPTH];
   logic [TAGW-1:0] fifo_rd [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   fifo_count;
   logic [TW-1:0]   tag_cnt, in_use;
   logic            kill, accept, tail_v, full, pop, push_ok, overflow, done_exp;

`ifdef MU_SCHED_FLUSH_EN
   // Occupancy of the multiplier itself; unlike tag_v it survives a flush so the
   // mu_done strobes of killed ops are still expected.
   logic [LAT-1:0] started;
   assign kill     = flush;
   assign done_exp = started[LAT-1];
   always_ff @(posedge clk) begin
      if (rst) started <= '0;
      else     started <= {started[LAT-2:0], mu_start};
   end
`else
   assign kill     = 1'b0;
   assign done_exp = tag_v[LAT-1];
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      tag_cnt = '0;
      for (int i = 0; i < LAT; i++) tag_cnt = tag_cnt + TW'(tag_v[i]);
   end

   // Every op between acceptance and writeback pop holds one credit.
   assign in_use    = TW'(mu_start) + tag_cnt + TW'(fifo_count);
   assign req_ready = !rst && !kill && (in_use < TW'(DEPTH));
   assign accept    = req_valid && req_ready;
   assign tail_v    = tag_v[LAT-1];
   assign full      = (fifo_count == CW'(DEPTH));
   assign wb_valid  = (fifo_count != '0);
   assign wb_data   = fifo_data[rd_ptr];
   assign wb_rd     = fifo_rd[rd_ptr];
   assign pop       = wb_valid && wb_ready;
   assign push_ok   = tail_v && (!full || pop);
   assign overflow  = tail_v && full && !pop;
   assign busy      = mu_start || (|tag_v) || wb_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         mu_start   <= 1'b0;
         mu_a       <= '0;
         mu_b       <= '0;
         mu_ctl     <= '0;
         issue_rd   <= '0;
         tag_v      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         err        <= 1'b0;
         for (int i = 0; i < LAT; i++) tag_rd[i] <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data[i] <= '0;
            fifo_rd[i]   <= '0;
         end
      end else begin
         mu_start <= accept;
         if (accept) begin
            mu_a     <= req_a;
            mu_b     <= req_b;
            mu_ctl   <= req_op;
            issue_rd <= req_rd;
         end

         tag_v     <= kill ? '0 : {tag_v[LAT-2:0], mu_start};
         tag_rd[0] <= issue_rd;
         for (int i = 1; i < LAT; i++) tag_rd[i] <= tag_rd[i-1];

         if (kill) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
         end else begin
            if (push_ok) begin
               fifo_data[wr_ptr] <= mu_res;
               fifo_rd[wr_ptr]   <= tag_rd[LAT-1];
               wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push_ok && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (!push_ok && pop) fifo_count <= fifo_count - CW'(1);
         end

         if ((mu_done != done_exp) || (overflow && !kill)) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mu_sched.sv
// Bench for mu_sched: behavioural multiplier, credit/latency model on queues, and directed
// plus random traffic checked every cycle.
module tb_mu_sched;
  localparam int LAT = 8;
  localparam int TAGW = 5;
  localparam int DEPTH = 4;
  localparam int W = TAGW + 32;

  logic clk = 0;
  logic rst, req_valid, req_ready, mu_start, mu_done, wb_valid, wb_ready, busy, err;
  logic [31:0] req_a, req_b, mu_a, mu_b, mu_res, wb_data;
  logic [1:0] req_op, mu_ctl;
  logic [TAGW-1:0] req_rd, wb_rd;
  logic flush_v = 1'b0;
  logic force_done = 1'b0;

  logic [W-1:0] exp_q[$];
  int tq[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, pops = 0;
  bit last_fire = 0, exp_err = 0;
  logic [31:0] last_a, last_b;
  logic [1:0] last_op;

  mu_sched #(.LAT(LAT), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_rd(req_rd),
    .mu_start(mu_start), .mu_a(mu_a), .mu_b(mu_b), .mu_ctl(mu_ctl),
    .mu_res(mu_res), .mu_done(mu_done), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .busy(busy), .err(err)
`ifdef MU_SCHED_FLUSH_EN
    , .flush(flush_v)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [63:0] ea, eb, p;
    ea = ((op == 2'b01 || op == 2'b10) && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    eb = ((op == 2'b01) && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    p = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // behavioural LAT-cycle multiplier environment
  logic pv [LAT];
  logic [31:0] pr [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= mu_start;
      pr[0] <= ref_mul(mu_a, mu_b, mu_ctl);
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pr[i] <= pr[i-1];
      end
    end
  end
  assign mu_done = pv[LAT-1] | force_done;
  assign mu_res = pr[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // one clock: check outputs against the model, account handshakes, advance
  task automatic cycle();
    bit fire, popv;
    logic [W-1:0] head;
    #1;
    check("req_ready", req_ready, !rst && !flush_v && (exp_q.size() < DEPTH));
    check("busy", busy, exp_q.size() != 0);
    check("wb_valid", wb_valid, (exp_q.size() > 0) ? (cyc >= tq[0] + LAT + 2) : 1'b0);
    check("mu_start", mu_start, last_fire);
    if (last_fire) begin
      check("mu_a", mu_a, last_a);
      check("mu_b", mu_b, last_b);
      check("mu_ctl", mu_ctl, last_op);
    end
    check("err", err, exp_err);
    popv = wb_valid && wb_ready && !rst && !flush_v;
    if (popv) begin
      if (exp_q.size() == 0) check("spurious_wb", 1, 0);
      else begin
        head = exp_q.pop_front();
        void'(tq.pop_front());
        check("wb_result", {wb_rd, wb_data}, head);
        pops++;
      end
    end
    fire = req_valid && req_ready;
    if (fire) begin
      exp_q.push_back({req_rd, ref_mul(req_a, req_b, req_op)});
      tq.push_back(cyc);
      last_a = req_a;
      last_b = req_b;
      last_op = req_op;
    end
    @(posedge clk);
    cyc++;
    last_fire = fire;
    if (rst || flush_v) begin
      exp_q.delete();
      tq.delete();
      last_fire = 0;
    end
    if (rst) exp_err = 0;
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           input logic [TAGW-1:0] rd);
    req_valid = 1; req_a = a; req_b = b; req_op = op; req_rd = rd;
  endtask

  task automatic drive_rand();
    drive_req($urandom, $urandom, 2'($urandom_range(0, 3)), TAGW'($urandom_range(0, 31)));
  endtask

  task automatic wait_wb(input string tag);
    for (int i = 0; i < 40 && !wb_valid; i++) cycle();
    check(tag, wb_valid, 1);
  endtask

  task automatic drain();
    req_valid = 0;
    wb_ready = 1;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int t0, acc, p0;
    rst = 1; req_valid = 0; req_a = 0; req_b = 0; req_op = 0; req_rd = 0; wb_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_outputs", {mu_start, mu_a, mu_b, mu_ctl, wb_valid, busy, err}, 0);
    check("rst_wb", {wb_rd, wb_data}, 0);
    rst = 0;

    // single op: 7*6 -> rd 3
    wb_ready = 1;
    drive_req(32'd7, 32'd6, 2'b00, 5'd3);
    t0 = cyc;
    cycle();
    req_valid = 0;
    wait_wb("single_wb");
    check("single_latency", cyc - t0, LAT + 2);
    check("single_result", {wb_rd, wb_data}, {5'd3, 32'd42});
    cycle();
    check("single_busy_fall", busy, 0);

    // credit limit under backpressure
    wb_ready = 0;
    acc = 0;
    drive_rand();
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (last_fire) begin acc++; drive_rand(); end
    end
    check("credit_accepted", acc, DEPTH);
    check("credit_ready_low", req_ready, 0);
    p0 = pops;
    drain();
    check("credit_pops", pops - p0, DEPTH);
    cycle();
    check("credit_ready_back", req_ready, 1);

    // mixed ops, in-order writeback
    wb_ready = 1;
    drive_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 5'd1);
    cycle();
    drive_req(32'hFFFF_FFFE, 32'd3, 2'b01, 5'd2);
    cycle();
    req_valid = 0;
    wait_wb("mixed_wb1");
    check("mulhu_result", {wb_rd, wb_data}, {5'd1, 32'hFFFF_FFFE});
    cycle();
    wait_wb("mixed_wb2");
    check("mulh_result", {wb_rd, wb_data}, {5'd2, 32'hFFFF_FFFF});
    drain();

    // fill the FIFO, then random traffic with toggling wb_ready
    wb_ready = 0;
    drive_rand();
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (last_fire) drive_rand();
    end
    for (int i = 0; i < 400; i++) begin
      wb_ready = $urandom_range(0, 1);
      cycle();
      if (last_fire || !req_valid) begin
        if ($urandom_range(0, 3) != 0) drive_rand();
        else req_valid = 0;
      end
    end
    drain();

    // reset with three ops in flight
    drive_rand();
    cycle(); drive_rand();
    cycle(); drive_rand();
    cycle();
    req_valid = 0;
    cycle(); cycle();
    rst = 1;
    cycle();
    rst = 0;
    #1;
    check("postrst_wb_valid", wb_valid, 0);
    check("postrst_busy", busy, 0);
    check("postrst_ready", req_ready, 1);
    for (int i = 0; i < 20; i++) cycle();

`ifdef MU_SCHED_FLUSH_EN
    drive_rand();
    cycle(); drive_rand();
    cycle();
    req_valid = 0;
    cycle(); cycle();
    flush_v = 1;
    cycle();
    flush_v = 0;
    for (int i = 0; i < 20; i++) cycle();
    check("flush_no_err", err, 0);
`endif

    // protocol error: mu_done with nothing in flight
    force_done = 1;
    cycle();
    force_done = 0;
    exp_err = 1;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1;
    cycle();
    rst = 0;
    cycle();
    check("err_cleared", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
